mem_arbiter: RTL and testbench

Memory-side responder for the cache request interface: accepts word read requests from the instruction cache and word read/write requests from the data cache, serialises them onto the single RAM port, and returns data plus a per-master wait handshake. Sits between the two L1 caches and the RAM model. The data cache has priority, bounded by an anti-starvation counter so instruction fetch cannot be locked out.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/diaosi_types_pkg.sv | 30 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types shared between the cpu, caches and ram model.
// Holds the ram handshake state and the word type.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg: state types for the L1 caches and the memory arbiter.
// Also carries the dcache streak counter type and its saturating step.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISERVE,
    DSERVE
  } arb_state_t;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_FILL
  } icache_state_t;

  typedef enum logic [2:0] {
    DC_IDLE,
    DC_WB,
    DC_FILL,
    DC_FLUSH,
    DC_HALT
  } dcache_state_t;

  typedef logic [2:0] streak_t;

  function automatic streak_t streak_inc(streak_t s);
    return (s == '1) ? s : s + 3'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache reads and dcache reads/writes onto one
// ram port; dcache wins unless icache has waited MAX_DSTREAK dcache grants.
module mem_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        err
);

  localparam streak_t LIMIT = streak_t'(MAX_DSTREAK);

  arb_state_t state, nstate;
  streak_t    dstreak, nstreak;

  logic d_req;
  logic d_serve;
  logic i_serve;
  logic d_done;
  logic i_done;
  logic err_set;

  assign d_req   = dREN | dWEN;
  assign d_serve = (state == DSERVE) && d_req;
  assign i_serve = (state == ISERVE) && iREN;
  assign d_done  = d_serve && (ramstate == ACCESS);
  assign i_done  = i_serve && (ramstate == ACCESS);

  // a dual read/write request is served as a write but flagged
  assign err_set = (d_serve && dREN && dWEN)
                || ((d_serve || i_serve) && (ramstate == ERROR));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
      err     <= 1'b0;
    end else begin
      state   <= nstate;
      dstreak <= nstreak;
      err     <= err | err_set;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (d_req && (dstreak < LIMIT))
          nstate = DSERVE;
        else if (iREN)
          nstate = ISERVE;
      end
      DSERVE: begin
        if (!d_req || (ramstate == ACCESS))
          nstate = IDLE;
      end
      ISERVE: begin
        if (!iREN || (ramstate == ACCESS))
          nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // streak only counts while an icache request is actually waiting
  always_comb begin
    nstreak = dstreak;
    if (!iREN || i_done)
      nstreak = '0;
    else if (d_done)
      nstreak = streak_inc(dstreak);
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state)
      DSERVE: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (d_done) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      ISERVE: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (i_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized two-master traffic
// scored against a word-memory reference and per-master expect queues.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  ramstate_t   ramstate = FREE;
  logic        err;

  mem_arbiter #(.MAX_DSTREAK(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .err(err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  bit ram_auto = 0;
  bit rnd_on = 0;
  int lat = 0;
  int istreak = 0;

  typedef struct {
    bit          wr;
    logic [31:0] data;
  } dexp_t;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] iq [$];
  dexp_t       dq [$];
  dexp_t       mon_e;

  function automatic logic [31:0] initval(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // ram model: random latency, answers from its own word memory
  always begin
    @(posedge CLK);
    #2;
    if (ram_auto) begin
      if (ramREN || ramWEN) begin
        if (lat == 0) begin
          ramstate = ACCESS;
          ramload = mem.exists(ramaddr) ? mem[ramaddr] : initval(ramaddr);
          if (ramWEN) mem[ramaddr] = ramstore;
          lat = $urandom_range(0, 3);
        end else begin
          lat--;
          ramstate = BUSY;
        end
      end else begin
        ramstate = FREE;
        lat = $urandom_range(0, 3);
      end
    end
  end

  always @(negedge CLK) begin
    if (rnd_on) begin
      chk("one_grant", 32'(!(!iwait && !dwait)), 32'd1);
      if (!iwait) begin
        if (iq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL i_extra: got %h want no completion", iload);
        end else
          chk("iload", iload, iq.pop_front());
      end
      if (!dwait) begin
        if (dq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL d_extra: got %h want no completion", dload);
        end else begin
          mon_e = dq.pop_front();
          if (!mon_e.wr) chk("dload", dload, mon_e.data);
        end
      end
      if (!iREN)
        istreak = 0;
      else if (!dwait) begin
        istreak++;
        chk("starve", 32'(istreak <= 4), 32'd1);
      end
      if (!iwait) istreak = 0;
    end
  end

  task automatic ireq(input logic [31:0] a);
    bit done = 0;
    int n = 0;
    iaddr = a;
    iq.push_back(initval(a));
    iREN = 1'b1;
    while (!done && n < 100) begin
      @(negedge CLK);
      done = !iwait;
      n++;
      tick();
    end
    iREN = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL i_timeout: got none want completion at %h", a);
    end
  endtask

  task automatic dreq(input bit wr, input logic [31:0] a,
                      input logic [31:0] d);
    bit done = 0;
    int n = 0;
    daddr = a;
    dstore = d;
    if (wr) begin
      shadow[a] = d;
      dq.push_back('{1'b1, d});
      dWEN = 1'b1;
    end else begin
      dq.push_back('{1'b0, shadow.exists(a) ? shadow[a] : initval(a)});
      dREN = 1'b1;
    end
    while (!done && n < 100) begin
      @(negedge CLK);
      done = !dwait;
      n++;
      tick();
    end
    dREN = 1'b0;
    dWEN = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL d_timeout: got none want completion at %h", a);
    end
  endtask

  byte got [$];
  byte expc;
  int  st;

  initial begin
    // reset values
    tick();
    tick();
    smp();
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_ren", 32'(ramREN), 32'd0);
    chk("rst_wen", 32'(ramWEN), 32'd0);
    chk("rst_addr", ramaddr, 32'd0);
    chk("rst_store", ramstore, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    nRST = 1'b1;

    // icache read, ACCESS on second serve cycle
    tick();
    iREN = 1'b1;
    iaddr = 32'h40;
    ramstate = BUSY;
    smp();
    chk("t1_idle_ren", 32'(ramREN), 32'd0);
    tick();
    smp();
    chk("t1_ren", 32'(ramREN), 32'd1);
    chk("t1_addr", ramaddr, 32'h40);
    chk("t1_iwait_busy", 32'(iwait), 32'd1);
    tick();
    ramstate = ACCESS;
    ramload = 32'hDEADBEEF;
    smp();
    chk("t1_iwait_done", 32'(iwait), 32'd0);
    chk("t1_iload", iload, 32'hDEADBEEF);
    tick();
    iREN = 1'b0;
    ramstate = FREE;
    smp();
    chk("t1_iwait_after", 32'(iwait), 32'd1);
    chk("t1_ren_after", 32'(ramREN), 32'd0);

    // dcache write beats concurrent icache read
    tick();
    iREN = 1'b1;
    iaddr = 32'h44;
    dWEN = 1'b1;
    daddr = 32'h80;
    dstore = 32'h1234;
    ramstate = BUSY;
    tick();
    smp();
    chk("t2_wen", 32'(ramWEN), 32'd1);
    chk("t2_ren", 32'(ramREN), 32'd0);
    chk("t2_store", ramstore, 32'h1234);
    chk("t2_addr", ramaddr, 32'h80);
    chk("t2_iwait_a", 32'(iwait), 32'd1);
    tick();
    ramstate = ACCESS;
    smp();
    chk("t2_dwait", 32'(dwait), 32'd0);
    chk("t2_iwait_b", 32'(iwait), 32'd1);
    tick();
    dWEN = 1'b0;
    ramstate = BUSY;
    smp();
    chk("t2_gap_ren", 32'(ramREN), 32'd0);
    chk("t2_iwait_c", 32'(iwait), 32'd1);
    tick();
    ramstate = ACCESS;
    ramload = 32'h5555;
    smp();
    chk("t2_iwait_done", 32'(iwait), 32'd0);
    chk("t2_iload", iload, 32'h5555);
    chk("t2_iaddr", ramaddr, 32'h44);
    tick();
    iREN = 1'b0;
    ramstate = FREE;

    // anti-starvation: continuous dREN with iREN held
    tick();
    dREN = 1'b1;
    daddr = 32'h100;
    iREN = 1'b1;
    iaddr = 32'h200;
    ramstate = ACCESS;
    for (int c = 0; c < 60 && got.size() < 10; c++) begin
      smp();
      if (!dwait) got.push_back(byte'("D"));
      if (!iwait) got.push_back(byte'("I"));
      tick();
    end
    if (got.size() < 10) begin
      total++;
      bad++;
      $display("FAIL t3_count: got %0d want 10 completions", got.size());
    end
    st = 0;
    for (int k = 0; k < got.size() && k < 10; k++) begin
      if (st >= 4) begin
        expc = byte'("I");
        st = 0;
      end else begin
        expc = byte'("D");
        st++;
      end
      chk("t3_seq", 32'(got[k]), 32'(expc));
    end
    dREN = 1'b0;
    iREN = 1'b0;
    ramstate = FREE;
    tick();
    tick();

    // dcache withdraws before ACCESS
    dREN = 1'b1;
    daddr = 32'h300;
    ramstate = BUSY;
    tick();
    smp();
    chk("t4_ren", 32'(ramREN), 32'd1);
    tick();
    dREN = 1'b0;
    smp();
    chk("t4_dwait_w", 32'(dwait), 32'd1);
    chk("t4_ren_w", 32'(ramREN), 32'd0);
    tick();
    ramstate = ACCESS;
    smp();
    chk("t4_dwait_idle", 32'(dwait), 32'd1);
    chk("t4_ren_idle", 32'(ramREN), 32'd0);
    chk("t4_addr_idle", ramaddr, 32'd0);
    tick();
    ramstate = FREE;

    // ram error for two cycles then ACCESS
    chk("t5_err_pre", 32'(err), 32'd0);
    iREN = 1'b1;
    iaddr = 32'h60;
    ramstate = BUSY;
    tick();
    ramstate = ERROR;
    smp();
    chk("t5_iwait_e1", 32'(iwait), 32'd1);
    tick();
    smp();
    chk("t5_err_set", 32'(err), 32'd1);
    chk("t5_iwait_e2", 32'(iwait), 32'd1);
    tick();
    ramstate = ACCESS;
    ramload = 32'hABCD;
    smp();
    chk("t5_iwait_done", 32'(iwait), 32'd0);
    chk("t5_iload", iload, 32'hABCD);
    tick();
    iREN = 1'b0;
    ramstate = FREE;
    smp();
    chk("t5_err_sticky", 32'(err), 32'd1);
    chk("t5_iwait_after", 32'(iwait), 32'd1);

    // reset during ISERVE
    tick();
    iREN = 1'b1;
    iaddr = 32'h70;
    ramstate = BUSY;
    tick();
    smp();
    chk("t6_ren_pre", 32'(ramREN), 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk("t6_ren_rst", 32'(ramREN), 32'd0);
    chk("t6_iwait_rst", 32'(iwait), 32'd1);
    chk("t6_addr_rst", ramaddr, 32'd0);
    chk("t6_err_rst", 32'(err), 32'd0);
    tick();
    tick();
    nRST = 1'b1;
    smp();
    chk("t6_ren_idle", 32'(ramREN), 32'd0);
    tick();
    ramstate = ACCESS;
    ramload = 32'h77;
    smp();
    chk("t6_iwait_done", 32'(iwait), 32'd0);
    chk("t6_iload", iload, 32'h77);
    chk("t6_addr", ramaddr, 32'h70);
    tick();
    iREN = 1'b0;
    ramstate = FREE;
    tick();

    // randomized concurrent traffic
    ram_auto = 1;
    rnd_on = 1;
    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) tick();
        ireq(32'($urandom_range(0, 255)) << 2);
      end
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 1) == 1)
          dreq(1'b1, 32'h1000 + (32'($urandom_range(0, 15)) << 2), $urandom);
        else
          dreq(1'b0, 32'h1000 + (32'($urandom_range(0, 15)) << 2), 32'd0);
      end
    join
    tick();
    rnd_on = 0;
    chk("iq_empty", 32'(iq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    chk("rnd_err", 32'(err), 32'd0);
    foreach (shadow[a])
      chk("mem_final", mem.exists(a) ? mem[a] : 32'hxxxxxxxx, shadow[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
